// File: rtl/riscv_ctrl_multicycle_if.sv
// ----------------------------------------------------------------------------
// riscv_ctrl_multicycle_if
// Bundle of the signals between the multicycle control unit and the
// shared RV32I datapath.
//
// Signals (datapath -> control):
//   iop[6:0]        instruction opcode from the instruction register
//   ifunct3[2:0]    instruction[14:12]
//   ifunct7b5       instruction[30]
//   izero           ALU zero flag
//   imem_ready      unified memory port completes its access this cycle
// Signals (control -> datapath):
//   opc_write       PC register enable
//   oaddr_src       memory address select (0 = PC, 1 = ALUOut)
//   oir_write       instruction register / OldPC enable
//   omem_write      memory write strobe
//   oreg_write      register-file write enable
//   oresult_src     result select (00 ALUOut, 01 Data, 10 ALU result)
//   oalu_src_a      ALU A select (00 PC, 01 OldPC, 10 RegA, 11 zero)
//   oalu_src_b      ALU B select (00 RegB, 01 ImmExt, 10 constant 4)
//   oalu_ctrl       ALU operation (000 add, 001 sub, 010 and, 011 or, 101 slt)
//   oimm_src        immediate format (000 I, 001 S, 010 B, 011 J, 100 U)
//   oillegal        unsupported opcode seen in DECODE
//   ostate          current FSM state encoding (debug)
// Modports: master = control unit, slave = datapath.
// ----------------------------------------------------------------------------
interface riscv_ctrl_multicycle_if;
  logic [6:0] iop;
  logic [2:0] ifunct3;
  logic       ifunct7b5;
  logic       izero;
  logic       imem_ready;
  logic       opc_write;
  logic       oaddr_src;
  logic       oir_write;
  logic       omem_write;
  logic       oreg_write;
  logic [1:0] oresult_src;
  logic [1:0] oalu_src_a;
  logic [1:0] oalu_src_b;
  logic [2:0] oalu_ctrl;
  logic [2:0] oimm_src;
  logic       oillegal;
  logic [3:0] ostate;

  modport master (
    input  iop, ifunct3, ifunct7b5, izero, imem_ready,
    output opc_write, oaddr_src, oir_write, omem_write, oreg_write,
           oresult_src, oalu_src_a, oalu_src_b, oalu_ctrl, oimm_src,
           oillegal, ostate
  );

  modport slave (
    output iop, ifunct3, ifunct7b5, izero, imem_ready,
    input  opc_write, oaddr_src, oir_write, omem_write, oreg_write,
           oresult_src, oalu_src_a, oalu_src_b, oalu_ctrl, oimm_src,
           oillegal, ostate
  );
endinterface

// File: rtl/riscv_ctrl_multicycle.sv
// ----------------------------------------------------------------------------
// riscv_ctrl_multicycle
// Moore-style control FSM for the multicycle RV32I subset core. Sequences the
// shared datapath through fetch/decode/execute/memory/writeback and drives
// every mux select and write enable.
//
// Ports:
//   iclk    core clock, rising edge
//   irst_n  asynchronous active-low reset (forces FETCH)
//   bus     riscv_ctrl_multicycle_if.master (decode inputs, control outputs)
//
// Optional feature macro: RISCV_CTRL_JALR_EN
//   When defined, opcode 1100111 (jalr) is supported via the JALR and
//   JALR_LINK states; otherwise it is reported as illegal.
// ----------------------------------------------------------------------------
module riscv_ctrl_multicycle (
  input  logic                          iclk,
  input  logic                          irst_n,
  riscv_ctrl_multicycle_if.master       bus
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXECR     = 4'd6,
    S_EXECI     = 4'd7,
    S_ALUWB     = 4'd8,
    S_BEQ       = 4'd9,
    S_JAL       = 4'd10,
    S_LUI       = 4'd11,
    S_JALR      = 4'd12,
    S_JALR_LINK = 4'd13
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] funct_alu;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) state_q <= S_FETCH;
    else         state_q <= state_d;
  end

  // ALU op for register and immediate arithmetic. iop[5] distinguishes
  // R-type from I-type so that addi never turns into a subtract.
  always_comb begin
    funct_alu = 3'b000;
    case (bus.ifunct3)
      3'b000:  funct_alu = (bus.ifunct7b5 && bus.iop[5]) ? 3'b001 : 3'b000;
      3'b010:  funct_alu = 3'b101;
      3'b110:  funct_alu = 3'b011;
      3'b111:  funct_alu = 3'b010;
      default: funct_alu = 3'b000;
    endcase
  end

  // The immediate format follows the opcode in every state so the extender
  // output is already valid when DECODE precomputes the branch target.
  always_comb begin
    bus.oimm_src = 3'b000;
    case (bus.iop)
      OP_SW:   bus.oimm_src = 3'b001;
      OP_BEQ:  bus.oimm_src = 3'b010;
      OP_JAL:  bus.oimm_src = 3'b011;
      OP_LUI:  bus.oimm_src = 3'b100;
      default: bus.oimm_src = 3'b000;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    bus.opc_write   = 1'b0;
    bus.oaddr_src   = 1'b0;
    bus.oir_write   = 1'b0;
    bus.omem_write  = 1'b0;
    bus.oreg_write  = 1'b0;
    bus.oresult_src = 2'b00;
    bus.oalu_src_a  = 2'b00;
    bus.oalu_src_b  = 2'b00;
    bus.oalu_ctrl   = 3'b000;
    bus.oillegal    = 1'b0;
    bus.ostate      = state_q;

    case (state_q)
      S_FETCH: begin
        bus.oalu_src_b  = 2'b10;
        bus.oresult_src = 2'b10;
        bus.oir_write   = bus.imem_ready;
        bus.opc_write   = bus.imem_ready;
        if (bus.imem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        bus.oalu_src_a = 2'b01;
        bus.oalu_src_b = 2'b01;
        case (bus.iop)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          OP_LUI:       state_d = S_LUI;
`ifdef RISCV_CTRL_JALR_EN
          OP_JALR:      state_d = S_JALR;
`endif
          default: begin
            bus.oillegal = 1'b1;
            state_d      = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        bus.oalu_src_a = 2'b10;
        bus.oalu_src_b = 2'b01;
        state_d = bus.iop[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        bus.oaddr_src = 1'b1;
        if (bus.imem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        bus.oresult_src = 2'b01;
        bus.oreg_write  = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEMWRITE: begin
        bus.oaddr_src  = 1'b1;
        bus.omem_write = 1'b1;
        if (bus.imem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        bus.oalu_src_a = 2'b10;
        bus.oalu_ctrl  = funct_alu;
        state_d        = S_ALUWB;
      end
      S_EXECI: begin
        bus.oalu_src_a = 2'b10;
        bus.oalu_src_b = 2'b01;
        bus.oalu_ctrl  = funct_alu;
        state_d        = S_ALUWB;
      end
      S_ALUWB: begin
        bus.oreg_write = 1'b1;
        state_d        = S_FETCH;
      end
      S_BEQ: begin
        bus.oalu_src_a = 2'b10;
        bus.oalu_ctrl  = 3'b001;
        bus.opc_write  = bus.izero;
        state_d        = S_FETCH;
      end
      S_JAL: begin
        // ALUOut still holds the target computed in DECODE; the ALU forms
        // the link value OldPC+4 for ALUWB.
        bus.oalu_src_a = 2'b01;
        bus.oalu_src_b = 2'b10;
        bus.opc_write  = 1'b1;
        state_d        = S_ALUWB;
      end
      S_LUI: begin
        bus.oalu_src_a = 2'b11;
        bus.oalu_src_b = 2'b01;
        state_d        = S_ALUWB;
      end
`ifdef RISCV_CTRL_JALR_EN
      S_JALR: begin
        // PC loads rs1+imm straight from the ALU result.
        bus.oalu_src_a  = 2'b10;
        bus.oalu_src_b  = 2'b01;
        bus.oresult_src = 2'b10;
        bus.opc_write   = 1'b1;
        state_d         = S_JALR_LINK;
      end
      S_JALR_LINK: begin
        // Separate from JAL so the PC is not overwritten with stale ALUOut.
        bus.oalu_src_a = 2'b01;
        bus.oalu_src_b = 2'b10;
        state_d        = S_ALUWB;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_riscv_ctrl_multicycle.sv
module tb_riscv_ctrl_multicycle;

  logic iclk;
  logic irst_n;

  riscv_ctrl_multicycle_if bus_if ();

  riscv_ctrl_multicycle dut (
    .iclk   (iclk),
    .irst_n (irst_n),
    .bus    (bus_if)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  // One instruction: st holds expected state per cycle (nibble c = cycle c),
  // rdy holds imem_ready per cycle (bit c = cycle c).
  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7b5;
    logic       zero;
    int         n;
    logic [31:0] st;
    logic [7:0]  rdy;
    int          mw_exp;   // expected omem_write cycles, -1 = not checked
  } vec_t;

  vec_t        vecs[$];
  logic [21:0] sb[$];
  int          checks = 0;
  int          errors = 0;

  // Expected outputs, packed as
  // {pc_write, addr_src, ir_write, mem_write, reg_write, result_src,
  //  alu_src_a, alu_src_b, alu_ctrl, imm_src, illegal, state}
  function automatic logic [21:0] exp_out(input logic [3:0] st, input logic [6:0] op,
                                           input logic [2:0] f3, input logic f7b5,
                                           input logic zero, input logic rdy);
    logic pcw, adr, irw, mw, rw, ill, legal;
    logic [1:0] res, a, b;
    logic [2:0] ctl, imm, fop;
    pcw = 0; adr = 0; irw = 0; mw = 0; rw = 0; ill = 0;
    res = 2'b00; a = 2'b00; b = 2'b00; ctl = 3'b000;
    case (op)
      7'b0100011: imm = 3'b001;
      7'b1100011: imm = 3'b010;
      7'b1101111: imm = 3'b011;
      7'b0110111: imm = 3'b100;
      default:    imm = 3'b000;
    endcase
    if (f3 == 3'b000)      fop = (f7b5 && op[5]) ? 3'b001 : 3'b000;
    else if (f3 == 3'b010) fop = 3'b101;
    else if (f3 == 3'b110) fop = 3'b011;
    else if (f3 == 3'b111) fop = 3'b010;
    else                   fop = 3'b000;
    legal = (op == 7'b0000011) || (op == 7'b0100011) || (op == 7'b0110011) ||
            (op == 7'b0010011) || (op == 7'b1100011) || (op == 7'b1101111) ||
            (op == 7'b0110111);
`ifdef RISCV_CTRL_JALR_EN
    legal = legal || (op == 7'b1100111);
`endif
    case (st)
      4'd0:  begin b = 2'b10; res = 2'b10; irw = rdy; pcw = rdy; end
      4'd1:  begin a = 2'b01; b = 2'b01; ill = !legal; end
      4'd2:  begin a = 2'b10; b = 2'b01; end
      4'd3:  adr = 1;
      4'd4:  begin res = 2'b01; rw = 1; end
      4'd5:  begin adr = 1; mw = 1; end
      4'd6:  begin a = 2'b10; b = 2'b00; ctl = fop; end
      4'd7:  begin a = 2'b10; b = 2'b01; ctl = fop; end
      4'd8:  rw = 1;
      4'd9:  begin a = 2'b10; ctl = 3'b001; pcw = zero; end
      4'd10: begin a = 2'b01; b = 2'b10; pcw = 1; end
      4'd11: begin a = 2'b11; b = 2'b01; end
      4'd12: begin a = 2'b10; b = 2'b01; res = 2'b10; pcw = 1; end
      4'd13: begin a = 2'b01; b = 2'b10; end
      default: ;
    endcase
    return {pcw, adr, irw, mw, rw, res, a, b, ctl, imm, ill, st};
  endfunction

  function automatic logic [21:0] dut_out();
    return {bus_if.opc_write, bus_if.oaddr_src, bus_if.oir_write, bus_if.omem_write,
            bus_if.oreg_write, bus_if.oresult_src, bus_if.oalu_src_a, bus_if.oalu_src_b,
            bus_if.oalu_ctrl, bus_if.oimm_src, bus_if.oillegal, bus_if.ostate};
  endfunction

  task automatic add_vec(input string name, input logic [6:0] op, input logic [2:0] f3,
                         input logic f7b5, input logic zero, input int n,
                         input logic [31:0] st, input logic [7:0] rdy, input int mw_exp);
    vec_t v;
    v.name = name; v.op = op; v.f3 = f3; v.f7b5 = f7b5; v.zero = zero;
    v.n = n; v.st = st; v.rdy = rdy; v.mw_exp = mw_exp;
    vecs.push_back(v);
  endtask

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  initial begin
    irst_n            = 1'b0;
    bus_if.imem_ready = 1'b0;
    bus_if.iop        = 7'b0;
    bus_if.ifunct3    = 3'b0;
    bus_if.ifunct7b5  = 1'b0;
    bus_if.izero      = 1'b0;

    // Hex nibbles read right-to-left: rightmost nibble is cycle 0.
    add_vec("lw",        7'b0000011, 3'b010, 0, 0, 5, 32'h00043210, 8'hFF,  0);
    add_vec("lw_stall",  7'b0000011, 3'b010, 0, 0, 7, 32'h04332100, 8'hEE,  0);
    add_vec("sw",        7'b0100011, 3'b010, 0, 0, 4, 32'h00005210, 8'hFF,  1);
    add_vec("sw_stall",  7'b0100011, 3'b010, 0, 0, 7, 32'h05555210, 8'hC7,  4);
    add_vec("r_add",     7'b0110011, 3'b000, 0, 0, 4, 32'h00008610, 8'hFF, -1);
    add_vec("r_sub",     7'b0110011, 3'b000, 1, 0, 4, 32'h00008610, 8'hFF, -1);
    add_vec("r_slt",     7'b0110011, 3'b010, 0, 0, 4, 32'h00008610, 8'hFF, -1);
    add_vec("r_or",      7'b0110011, 3'b110, 0, 0, 4, 32'h00008610, 8'hFF, -1);
    add_vec("r_and",     7'b0110011, 3'b111, 0, 0, 4, 32'h00008610, 8'hFF, -1);
    add_vec("r_f3_001",  7'b0110011, 3'b001, 1, 0, 4, 32'h00008610, 8'hFF, -1);
    add_vec("i_addi_b5", 7'b0010011, 3'b000, 1, 0, 4, 32'h00008710, 8'hFF, -1);
    add_vec("i_ori",     7'b0010011, 3'b110, 0, 0, 4, 32'h00008710, 8'hFF, -1);
    add_vec("beq_taken", 7'b1100011, 3'b000, 0, 1, 3, 32'h00000910, 8'hFF, -1);
    add_vec("beq_not",   7'b1100011, 3'b000, 0, 0, 3, 32'h00000910, 8'hFF, -1);
    add_vec("jal",       7'b1101111, 3'b000, 0, 0, 4, 32'h00008A10, 8'hFF, -1);
    add_vec("lui",       7'b0110111, 3'b000, 0, 0, 4, 32'h00008B10, 8'hFF, -1);
`ifdef RISCV_CTRL_JALR_EN
    add_vec("jalr",      7'b1100111, 3'b000, 0, 0, 5, 32'h0008DC10, 8'hFF, -1);
`else
    add_vec("jalr_ill",  7'b1100111, 3'b000, 0, 0, 2, 32'h00000010, 8'hFF, -1);
`endif
    add_vec("illegal",   7'b0000000, 3'b000, 0, 0, 2, 32'h00000010, 8'hFF,  0);

    // Reset state: FETCH, enables follow imem_ready even while in reset.
    #2;
    check1("rst_state",   {28'd0, bus_if.ostate}, 32'd0);
    check1("rst_ir_pc_0", {30'd0, bus_if.oir_write, bus_if.opc_write}, 32'd0);
    check1("rst_illegal", {31'd0, bus_if.oillegal}, 32'd0);
    bus_if.imem_ready = 1'b1;
    #1;
    check1("rst_ir_pc_1", {30'd0, bus_if.oir_write, bus_if.opc_write}, 32'd3);
    bus_if.imem_ready = 1'b0;
    @(negedge iclk);
    irst_n = 1'b1;
    @(posedge iclk); #1;

    foreach (vecs[i]) begin
      int mw_cnt;
      mw_cnt = 0;
      bus_if.iop       = vecs[i].op;
      bus_if.ifunct3   = vecs[i].f3;
      bus_if.ifunct7b5 = vecs[i].f7b5;
      bus_if.izero     = vecs[i].zero;
      for (int c = 0; c < vecs[i].n; c++) begin
        logic [21:0] got, exp;
        bus_if.imem_ready = vecs[i].rdy[c];
        sb.push_back(exp_out(vecs[i].st[4*c +: 4], vecs[i].op, vecs[i].f3,
                             vecs[i].f7b5, vecs[i].zero, vecs[i].rdy[c]));
        @(negedge iclk);
        got = dut_out();
        exp = sb.pop_front();
        if (bus_if.omem_write) mw_cnt++;
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL %s cyc%0d: got %b expected %b", vecs[i].name, c, got, exp);
        end
        @(posedge iclk); #1;
      end
      if (vecs[i].mw_exp >= 0)
        check1({vecs[i].name, "_mw_cycles"}, mw_cnt, vecs[i].mw_exp);
      check1({vecs[i].name, "_back_to_fetch"}, {28'd0, bus_if.ostate}, 32'd0);
      $display("txn %s op=%b f3=%b f7b5=%0d zero=%0d cycles=%0d done",
               vecs[i].name, vecs[i].op, vecs[i].f3, vecs[i].f7b5, vecs[i].zero, vecs[i].n);
    end

    // Reset asserted while a store is stalled in MEMWRITE.
    bus_if.iop     = 7'b0100011;
    bus_if.ifunct3 = 3'b010;
    for (int c = 0; c < 4; c++) begin
      bus_if.imem_ready = (c < 3);
      @(negedge iclk);
      if (c < 3) begin
        @(posedge iclk); #1;
      end
    end
    check1("mw_stalled_state", {28'd0, bus_if.ostate}, 32'd5);
    check1("mw_stalled_strobe", {31'd0, bus_if.omem_write}, 32'd1);
    #2;
    irst_n = 1'b0;
    #1;
    check1("async_rst_state", {28'd0, bus_if.ostate}, 32'd0);
    check1("async_rst_strobe", {31'd0, bus_if.omem_write}, 32'd0);
    #1;
    irst_n = 1'b1;
    @(posedge iclk); #1;
    check1("post_rst_hold_fetch", {28'd0, bus_if.ostate}, 32'd0);
    $display("txn reset_mid_memwrite done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
